// File: rtl/tick_scheduler.sv
// Time-base sequencer: 1 s tick, display scan tick with digit index, blink wave, run/hold/sync FSM.
// Optional FAST_ADV_EN macro adds the fast_adv input (8x seconds rate while setting the time).
module tick_scheduler #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned SEC_HZ   = 1,
   parameter int unsigned SCAN_HZ  = 1000,
   parameter int unsigned BLINK_HZ = 2,
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned CNT_W    = 26
) (
   input  logic       clk_in_50M,
   input  logic       rst,
   input  logic       run_en,
   input  logic       pause_req,
   input  logic       sync_req,
`ifdef FAST_ADV_EN
   input  logic       fast_adv,
`endif
   output logic       tick_1s,
   output logic       tick_scan,
   output logic [2:0] scan_idx,
   output logic       blink,
   output logic [1:0] state
);

   localparam int unsigned DIV_1S   = CLK_HZ / SEC_HZ;
   localparam int unsigned DIV_SCAN = CLK_HZ / SCAN_HZ;
   localparam int unsigned DIV_BLK  = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned DIV_FAST = DIV_1S / 8;
   localparam int unsigned SCAN_W   = $clog2(DIV_SCAN);
   localparam int unsigned BLK_W    = $clog2(DIV_BLK);

   if (DIV_1S < 2 || DIV_SCAN < 2 || DIV_BLK < 2 || DIGITS > 8 || DIGITS < 1 ||
       64'(DIV_1S) > (64'd1 << CNT_W)) begin : g_bad_cfg
      $error("tick_scheduler: invalid divider, DIGITS or CNT_W configuration");
   end

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_SYNC = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_nxt;
   logic [CNT_W-1:0]   sec_cnt;
   logic [CNT_W-1:0]   sec_nxt;
   logic [CNT_W-1:0]   sec_term;
   logic               tick_1s_nxt;
   logic               fast_chg;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [BLK_W-1:0]   blk_cnt;

`ifdef FAST_ADV_EN
   if (DIV_FAST < 2) begin : g_bad_fast
      $error("tick_scheduler: DIV_1S too small for fast advance");
   end

   logic fast_q;

   // Remember fast_adv so a mode change can restart the seconds phase
   always_ff @(posedge clk_in_50M or posedge rst) begin
      if (rst) fast_q <= 1'b0;
      else     fast_q <= fast_adv;
   end

   assign fast_chg = fast_adv ^ fast_q;
   assign sec_term = fast_adv ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_1S - 1);
`else
   assign fast_chg = 1'b0;
   assign sec_term = CNT_W'(DIV_1S - 1);
`endif

   // Next state, seconds count and tick decision
   always_comb begin
      state_nxt   = state_q;
      sec_nxt     = sec_cnt;
      tick_1s_nxt = 1'b0;

      if (!run_en)                               state_nxt = ST_STOP;
      else if (state_q == ST_STOP)               state_nxt = ST_RUN;
      else if (sync_req)                         state_nxt = ST_SYNC;
      else if (state_q == ST_SYNC)               state_nxt = pause_req ? ST_HOLD : ST_RUN;
      else if (state_q == ST_RUN && pause_req)   state_nxt = ST_HOLD;
      else if (state_q == ST_HOLD && !pause_req) state_nxt = ST_RUN;

      // A wrap on the edge that leaves RUN is dropped, never deferred
      if (state_q == ST_RUN && state_nxt == ST_RUN) begin
         if (sec_cnt == sec_term) begin
            sec_nxt     = '0;
            tick_1s_nxt = 1'b1;
         end else begin
            sec_nxt = sec_cnt + CNT_W'(1);
         end
      end else if (state_nxt == ST_STOP || state_nxt == ST_SYNC) begin
         sec_nxt = '0;
      end

      if (fast_chg) begin
         sec_nxt     = '0;
         tick_1s_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_in_50M or posedge rst) begin
      if (rst) begin
         state_q <= ST_STOP;
         sec_cnt <= '0;
         tick_1s <= 1'b0;
      end else begin
         state_q <= state_nxt;
         sec_cnt <= sec_nxt;
         tick_1s <= tick_1s_nxt;
      end
   end

   assign state = state_q;

   // Display scan runs in every state so the display stays lit while setting
   always_ff @(posedge clk_in_50M or posedge rst) begin
      if (rst) begin
         scan_cnt  <= '0;
         tick_scan <= 1'b0;
         scan_idx  <= 3'd0;
      end else if (scan_cnt == SCAN_W'(DIV_SCAN - 1)) begin
         scan_cnt  <= '0;
         tick_scan <= 1'b1;
         scan_idx  <= (scan_idx == 3'(DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
      end else begin
         scan_cnt  <= scan_cnt + SCAN_W'(1);
         tick_scan <= 1'b0;
      end
   end

   // Free-running blink half-period counter
   always_ff @(posedge clk_in_50M or posedge rst) begin
      if (rst) begin
         blk_cnt <= '0;
         blink   <= 1'b0;
      end else if (blk_cnt == BLK_W'(DIV_BLK - 1)) begin
         blk_cnt <= '0;
         blink   <= ~blink;
      end else begin
         blk_cnt <= blk_cnt + BLK_W'(1);
      end
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus random run/pause/sync traffic against a cycle model.
// Builds with or without FAST_ADV_EN.
module tb_tick_scheduler;

   localparam int unsigned CLK_HZ   = 1000;
   localparam int unsigned SEC_HZ   = 1;
   localparam int unsigned SCAN_HZ  = 100;
   localparam int unsigned BLINK_HZ = 2;
   localparam int unsigned DIGITS   = 8;
   localparam int          DIV_1S   = int'(CLK_HZ / SEC_HZ);
   localparam int          DIV_SCAN = int'(CLK_HZ / SCAN_HZ);
   localparam int          DIV_BLK  = int'(CLK_HZ / (2 * BLINK_HZ));
`ifdef FAST_ADV_EN
   localparam bit HAS_FAST = 1'b1;
`else
   localparam bit HAS_FAST = 1'b0;
`endif

   logic       clk_in_50M = 1'b0;
   logic       rst;
   logic       run_en;
   logic       pause_req;
   logic       sync_req;
   logic       fast_adv;
   logic       tick_1s;
   logic       tick_scan;
   logic [2:0] scan_idx;
   logic       blink;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   // reference model: cycles since reset, spec-level state and elapsed run cycles
   int m_n, m_state, m_sec, m_tick, m_fast_q;

   tick_scheduler #(
      .CLK_HZ(CLK_HZ), .SEC_HZ(SEC_HZ), .SCAN_HZ(SCAN_HZ),
      .BLINK_HZ(BLINK_HZ), .DIGITS(DIGITS), .CNT_W(26)
   ) dut (
      .clk_in_50M(clk_in_50M),
      .rst(rst),
      .run_en(run_en),
      .pause_req(pause_req),
      .sync_req(sync_req),
`ifdef FAST_ADV_EN
      .fast_adv(fast_adv),
`endif
      .tick_1s(tick_1s),
      .tick_scan(tick_scan),
      .scan_idx(scan_idx),
      .blink(blink),
      .state(state)
   );

   always #5 clk_in_50M = ~clk_in_50M;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_state = 0; m_sec = 0; m_tick = 0; m_fast_q = 0;
   endtask

   // One clock edge of the spec: priority-ordered transitions, seconds phase counted in RUN
   task automatic model_edge();
      int nxt;
      int period;
      m_n++;
      if (!run_en)                           nxt = 0;
      else if (m_state == 0)                 nxt = 1;
      else if (sync_req)                     nxt = 3;
      else if (m_state == 3)                 nxt = pause_req ? 2 : 1;
      else if (m_state == 1 && pause_req)    nxt = 2;
      else if (m_state == 2 && !pause_req)   nxt = 1;
      else                                   nxt = m_state;
      period = (HAS_FAST && fast_adv) ? DIV_1S / 8 : DIV_1S;
      m_tick = 0;
      if (m_state == 1 && nxt == 1) begin
         m_sec++;
         if (m_sec >= period) begin
            m_sec  = 0;
            m_tick = 1;
         end
      end else if (nxt == 0 || nxt == 3) begin
         m_sec = 0;
      end
      if (HAS_FAST && int'(fast_adv) != m_fast_q) begin
         m_sec  = 0;
         m_tick = 0;
      end
      m_fast_q = int'(fast_adv);
      m_state  = nxt;
   endtask

   task automatic compare_all();
      check("state", int'(state), m_state);
      check("tick_1s", int'(tick_1s), m_tick);
      check("tick_scan", int'(tick_scan), (m_n != 0 && m_n % DIV_SCAN == 0) ? 1 : 0);
      check("scan_idx", int'(scan_idx), (m_n / DIV_SCAN) % int'(DIGITS));
      check("blink", int'(blink), (m_n / DIV_BLK) % 2);
   endtask

   task automatic step();
      @(posedge clk_in_50M);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run_until_tick(input string tag, input int max_c, input int exp_gap);
      int cyc;
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (tick_1s !== 1'b1 && cyc < max_c);
      check({tag, "_seen"}, int'(tick_1s), 1);
      check({tag, "_gap"}, cyc, exp_gap);
   endtask

   task automatic enter_run();
      run_en = 1'b0; pause_req = 1'b0; sync_req = 1'b0; fast_adv = 1'b0;
      step();
      run_en = 1'b1;
      step();
      check("run_entry", int'(state), 1);
   endtask

   task automatic run_to_sec(input int target);
      for (int k = 0; k < 2 * DIV_1S && m_sec != target; k++) step();
   endtask

   initial begin
      int nscan;
      int nticks;
      rst = 1'b1; run_en = 1'b0; pause_req = 1'b0; sync_req = 1'b0; fast_adv = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_in_50M);
      #1;
      compare_all();
      rst = 1'b0;

      // 1: three 1 s ticks after entering RUN
      run_en = 1'b1;
      step();
      check("t1_state_run", int'(state), 1);
      for (int i = 0; i < 3; i++) begin
         run_until_tick("t1_tick", DIV_1S + 100, DIV_1S);
         step();
         check("t1_width", int'(tick_1s), 0);
         run_to_sec(0);
      end

      // 2: scan and blink keep going in STOP
      run_en = 1'b0;
      nscan = 0;
      for (int i = 0; i < 800; i++) begin
         step();
         nscan += int'(tick_scan);
      end
      check("t2_scan_count", nscan, 800 / DIV_SCAN);

      // 3: pause at 600 for 400 cycles, then 400 more cycles to the tick
      enter_run();
      run_to_sec(600);
      pause_req = 1'b1;
      nticks = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         nticks += int'(tick_1s);
      end
      check("t3_hold_state", int'(state), 2);
      check("t3_no_tick", nticks, 0);
      pause_req = 1'b0;
      step();
      run_until_tick("t3_resume", DIV_1S, 400);

      // 4: sync with pause at 900 -> SYNC, HOLD, then a full period after release
      enter_run();
      run_to_sec(900);
      sync_req = 1'b1; pause_req = 1'b1;
      step();
      check("t4_sync", int'(state), 3);
      sync_req = 1'b0;
      step();
      check("t4_hold", int'(state), 2);
      repeat (50) step();
      pause_req = 1'b0;
      step();
      run_until_tick("t4_resume", DIV_1S + 100, DIV_1S);

      // 5: async reset one cycle before a wrap
      enter_run();
      run_to_sec(999);
      @(negedge clk_in_50M);
      rst = 1'b1;
      #1;
      check("t5_state", int'(state), 0);
      check("t5_tick_1s", int'(tick_1s), 0);
      check("t5_tick_scan", int'(tick_scan), 0);
      check("t5_scan_idx", int'(scan_idx), 0);
      check("t5_blink", int'(blink), 0);
      @(posedge clk_in_50M);
      #1;
      check("t5_no_late_tick", int'(tick_1s), 0);
      rst = 1'b0;
      model_reset();

`ifdef FAST_ADV_EN
      // 6: fast advance gives 8x ticks, normal rate after release
      enter_run();
      fast_adv = 1'b1;
      step();
      run_until_tick("t6_fast", DIV_1S, DIV_1S / 8);
      run_until_tick("t6_fast2", DIV_1S, DIV_1S / 8);
      fast_adv = 1'b0;
      step();
      run_until_tick("t6_slow", DIV_1S + 100, DIV_1S);
`endif

      // random traffic, every cycle checked against the model
      for (int seg = 0; seg < 40; seg++) begin
         int len;
         int slen;
         run_en    = ($urandom_range(0, 9) != 0);
         pause_req = ($urandom_range(0, 3) == 0);
         fast_adv  = HAS_FAST && ($urandom_range(0, 2) == 0);
         len       = int'($urandom_range(1, 400));
         slen      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
         for (int k = 0; k < len; k++) begin
            sync_req = (k < slen);
            step();
         end
      end
      sync_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
